// File: rtl/id_issue_pkg.sv
// Shared ALU function codes, MIPS encodings and op bundle.
// Used by the decoder, the issue buffer and the ALU.
package id_issue_pkg;

  typedef enum logic [5:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b011000,
    ALU_OR  = 6'b011110,
    ALU_XOR = 6'b010110,
    ALU_NOR = 6'b010001,
    ALU_SLL = 6'b100000,
    ALU_SRL = 6'b100001,
    ALU_SRA = 6'b100011,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101,
    ALU_LEZ = 6'b111101,
    ALU_GEZ = 6'b111001,
    ALU_GTZ = 6'b111111
  } alu_fun_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_fun_e    fun;
    logic        sign;
    logic [4:0]  reg_dst;
    logic        reg_write;
    logic        illegal;
  } alu_op_t;

  function automatic logic [31:0] sext16(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(logic [15:0] v);
    return {16'd0, v};
  endfunction

  // Unsupported encodings issue as a harmless ADD 0,0 with no write.
  function automatic alu_op_t illegal_op();
    alu_op_t o;
    o = '0;
    o.fun = ALU_ADD;
    o.illegal = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/id_issue_if.sv
// Upstream instruction beat and downstream ALU op handshakes.
// slave = the issue stage, master = the driver/consumer side.
interface id_issue_if;

  logic        iInstValid;
  logic        oInstReady;
  logic [31:0] iInstr;
  logic [31:0] iRsData;
  logic [31:0] iRtData;

  logic        oValid;
  logic        iExReady;
  logic [31:0] oA;
  logic [31:0] oB;
  logic [5:0]  oALUFun;
  logic        oSign;
  logic [4:0]  oRegDst;
  logic        oRegWrite;
  logic        oIllegal;

  modport slave (
    input  iInstValid, iInstr, iRsData, iRtData, iExReady,
    output oInstReady, oValid, oA, oB, oALUFun, oSign,
    output oRegDst, oRegWrite, oIllegal
  );

  modport master (
    output iInstValid, iInstr, iRsData, iRtData, iExReady,
    input  oInstReady, oValid, oA, oB, oALUFun, oSign,
    input  oRegDst, oRegWrite, oIllegal
  );

endinterface

// File: rtl/id_issue_alu_op_decode.sv
// Combinational MIPS -> ALU op decoder.
// Operand muxing is done here so the buffer stores ready operands.
module alu_op_decode
  import id_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output alu_op_t     op
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        unused_rs_field;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // rs arrives already read from the register file.
  assign unused_rs_field = ^instr[25:21];

  // Decode by opcode, then by funct for R-type.
  always_comb begin
    op = '0;
    op.fun = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        op.a = rs_data;
        op.b = rt_data;
        op.reg_dst = rd_f;
        op.reg_write = 1'b1;
        unique case (funct)
          FN_ADD: begin
            op.fun = ALU_ADD;
            op.sign = 1'b1;
          end
          FN_ADDU: op.fun = ALU_ADD;
          FN_SUB: begin
            op.fun = ALU_SUB;
            op.sign = 1'b1;
          end
          FN_SUBU: op.fun = ALU_SUB;
          FN_AND:  op.fun = ALU_AND;
          FN_OR:   op.fun = ALU_OR;
          FN_XOR:  op.fun = ALU_XOR;
          FN_NOR:  op.fun = ALU_NOR;
          FN_SLT: begin
            op.fun = ALU_LT;
            op.sign = 1'b1;
          end
          FN_SLTU: op.fun = ALU_LT;
          FN_SLL: begin
            op.fun = ALU_SLL;
            op.a = {27'd0, shamt};
          end
          FN_SRL: begin
            op.fun = ALU_SRL;
            op.a = {27'd0, shamt};
          end
          FN_SRA: begin
            op.fun = ALU_SRA;
            op.a = {27'd0, shamt};
          end
          default: op = illegal_op();
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        op.a = rs_data;
        op.b = sext16(imm);
        op.reg_dst = rt_f;
        op.reg_write = 1'b1;
        op.sign = (opcode == OP_ADDI)
               || (opcode == OP_SLTI);
        op.fun = (opcode == OP_SLTI || opcode == OP_SLTIU)
               ? ALU_LT : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        op.a = rs_data;
        op.b = zext16(imm);
        op.reg_dst = rt_f;
        op.reg_write = 1'b1;
        unique case (opcode)
          OP_ANDI: op.fun = ALU_AND;
          OP_ORI:  op.fun = ALU_OR;
          default: op.fun = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        op.fun = ALU_SLL;
        op.a = 32'd16;
        op.b = zext16(imm);
        op.reg_dst = rt_f;
        op.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        op.fun = (opcode == OP_BEQ) ? ALU_EQ : ALU_NEQ;
        op.a = rs_data;
        op.b = rt_data;
        op.sign = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        op.fun = (opcode == OP_BLEZ) ? ALU_LEZ : ALU_GTZ;
        op.a = rs_data;
        op.sign = 1'b1;
      end
      OP_REGIMM: begin
        if (rt_f == RT_BGEZ) begin
          op.fun = ALU_GEZ;
          op.a = rs_data;
          op.sign = 1'b1;
        end else begin
          op = illegal_op();
        end
      end
      default: op = illegal_op();
    endcase
    // Writes to $zero are dropped at issue.
    if (op.reg_dst == 5'd0) op.reg_write = 1'b0;
  end

endmodule

// File: rtl/id_issue.sv
// Decode/issue stage: decodes beats and buffers them in a
// two-entry skid buffer (main + skid) ahead of the ALU.
module id_issue
  import id_issue_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iFlush,
  id_issue_if.slave  bus
);

  alu_op_t dec_op;
  alu_op_t main_q, main_d;
  alu_op_t skid_q, skid_d;
  logic    main_v_q, main_v_d;
  logic    skid_v_q, skid_v_d;
  logic    ready_q;
  logic    accept;
  logic    issue;

  alu_op_decode u_dec (
    .instr   (bus.iInstr),
    .rs_data (bus.iRsData),
    .rt_data (bus.iRtData),
    .op      (dec_op)
  );

  // ready_q always mirrors "skid empty", kept as its own flop.
  assign accept = bus.iInstValid & ready_q;
  assign issue  = main_v_q & bus.iExReady;

  // Buffer next state; flush wins over accept and issue.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (iFlush) begin
      main_d   = '0;
      skid_d   = '0;
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || issue) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = dec_op;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = dec_op;
      skid_v_d = 1'b1;
    end
  end

  // Buffer registers; reset clears everything and wins over flush.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ~skid_v_d;
    end
  end

  assign bus.oInstReady = ready_q;
  assign bus.oValid     = main_v_q;
  assign bus.oA         = main_q.a;
  assign bus.oB         = main_q.b;
  assign bus.oALUFun    = main_q.fun;
  assign bus.oSign      = main_q.sign;
  assign bus.oRegDst    = main_q.reg_dst;
  assign bus.oRegWrite  = main_q.reg_write;
  assign bus.oIllegal   = main_q.illegal;

endmodule

// File: tb/tb_id_issue.sv
// Directed bench for id_issue with an issue-order scoreboard.
// Expected ops are hand-written constants pushed on acceptance.
module tb_id_issue;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  dst;
    logic        we;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;
  exp_t sbq[$];
  exp_t cur_exp;
  exp_t snap;
  exp_t e_add, e_a, e_b, e_c;

  id_issue_if bus ();

  id_issue dut (
    .iClk   (clk),
    .iRst   (rst),
    .iFlush (flush),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(logic [31:0] a, logic [31:0] b,
                              logic [5:0] f, logic s,
                              logic [4:0] d, logic w, logic i);
    exp_t e;
    e = {a, b, f, s, d, w, i};
    return e;
  endfunction

  function automatic exp_t obs_op();
    return mk(bus.oA, bus.oB, bus.oALUFun, bus.oSign,
              bus.oRegDst, bus.oRegWrite, bus.oIllegal);
  endfunction

  function automatic void chk_op(string tag, exp_t obs, exp_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  function automatic void chk_b(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endfunction

  task automatic offer(logic [31:0] ins, logic [31:0] rs,
                       logic [31:0] rt, exp_t e);
    bus.iInstValid = 1'b1;
    bus.iInstr     = ins;
    bus.iRsData    = rs;
    bus.iRtData    = rt;
    cur_exp        = e;
  endtask

  task automatic idle();
    bus.iInstValid = 1'b0;
  endtask

  // Observe handshakes mid-cycle, then advance past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst || flush) begin
      sbq.delete();
    end else begin
      if (bus.oValid && bus.iExReady) begin
        if (sbq.size() == 0) begin
          chk_b("spurious_issue", bus.oValid, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk_op("issue", obs_op(), e);
        end
      end
      if (bus.iInstValid && bus.oInstReady) sbq.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) tick();
    chk_b("drain_empty", sbq.size() == 0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.iInstValid = 1'b0;
    bus.iInstr = '0;
    bus.iRsData = '0;
    bus.iRtData = '0;
    bus.iExReady = 1'b0;
    cur_exp = '0;

    // reset state
    tick();
    tick();
    chk_b("rst_valid", bus.oValid, 1'b0);
    chk_b("rst_ready", bus.oInstReady, 1'b1);
    chk_op("rst_out", obs_op(), '0);
    rst = 1'b0;

    // add $3,$1,$2 with latency 1
    bus.iExReady = 1'b1;
    e_add = mk(32'd5, 32'd7, 6'b000000, 1'b1, 5'd3, 1'b1, 1'b0);
    offer(32'h00221820, 32'd5, 32'd7, e_add);
    tick();
    idle();
    chk_b("add_lat1", bus.oValid, 1'b1);
    chk_op("add_out", obs_op(), e_add);
    drain();

    // backpressure: 3 beats offered while EX stalls
    bus.iExReady = 1'b0;
    e_a = mk(32'd10, 32'd3, 6'b000001, 1'b1, 5'd5, 1'b1, 1'b0);
    e_b = mk(32'h0000F0F0, 32'h00000FF0, 6'b011000,
             1'b0, 5'd8, 1'b1, 1'b0);
    e_c = mk(32'h1, 32'h2, 6'b011110, 1'b0, 5'd11, 1'b1, 1'b0);
    offer(32'h00C72822, 32'd10, 32'd3, e_a);
    tick();
    snap = obs_op();
    chk_op("bp_main", snap, e_a);
    chk_b("bp_ready1", bus.oInstReady, 1'b1);
    offer(32'h012A4024, 32'h0000F0F0, 32'h00000FF0, e_b);
    tick();
    chk_b("bp_ready_full", bus.oInstReady, 1'b0);
    chk_op("bp_hold1", obs_op(), snap);
    offer(32'h018D5825, 32'h1, 32'h2, e_c);
    tick();
    chk_b("bp_ready_still", bus.oInstReady, 1'b0);
    chk_b("bp_valid", bus.oValid, 1'b1);
    chk_op("bp_hold2", obs_op(), snap);
    bus.iExReady = 1'b1;
    tick();
    tick();
    idle();
    drain();

    // immediates, lui, shift, write to $zero, streamed
    offer(32'h3C041234, 32'h99, 32'h77,
          mk(32'd16, 32'h00001234, 6'b100000,
             1'b0, 5'd4, 1'b1, 1'b0));
    tick();
    offer(32'h2026FFFF, 32'd3, 32'h77,
          mk(32'd3, 32'hFFFFFFFF, 6'b000000,
             1'b1, 5'd6, 1'b1, 1'b0));
    tick();
    offer(32'h3027FFFF, 32'd9, 32'h77,
          mk(32'd9, 32'h0000FFFF, 6'b011000,
             1'b0, 5'd7, 1'b1, 1'b0));
    tick();
    offer(32'h00031100, 32'h5, 32'h11,
          mk(32'd4, 32'h11, 6'b100000,
             1'b0, 5'd2, 1'b1, 1'b0));
    tick();
    offer(32'h00220020, 32'd1, 32'd2,
          mk(32'd1, 32'd2, 6'b000000,
             1'b1, 5'd0, 1'b0, 1'b0));
    tick();
    chk_b("stream_ready", bus.oInstReady, 1'b1);
    idle();
    drain();

    // branches and illegal encodings
    offer(32'h04410010, 32'h80000000, 32'h77,
          mk(32'h80000000, 32'h0, 6'b111001,
             1'b1, 5'd0, 1'b0, 1'b0));
    tick();
    offer(32'h10220005, 32'd9, 32'd9,
          mk(32'd9, 32'd9, 6'b110011, 1'b1, 5'd0, 1'b0, 1'b0));
    tick();
    offer(32'h18600004, 32'h0, 32'h55,
          mk(32'h0, 32'h0, 6'b111101, 1'b1, 5'd0, 1'b0, 1'b0));
    tick();
    offer(32'hFC000000, 32'd1, 32'd2,
          mk(32'h0, 32'h0, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b1));
    tick();
    offer(32'h0022183F, 32'd1, 32'd2,
          mk(32'h0, 32'h0, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b1));
    tick();
    idle();
    drain();

    // flush with full buffer and a new beat offered
    bus.iExReady = 1'b0;
    offer(32'h00221820, 32'd5, 32'd7, e_add);
    tick();
    offer(32'h00C72822, 32'd10, 32'd3, e_a);
    tick();
    chk_b("fl_full", bus.oInstReady, 1'b0);
    flush = 1'b1;
    bus.iExReady = 1'b1;
    offer(32'h018D5825, 32'h1, 32'h2, e_c);
    tick();
    flush = 1'b0;
    idle();
    chk_b("fl_valid", bus.oValid, 1'b0);
    chk_b("fl_ready", bus.oInstReady, 1'b1);
    repeat (4) tick();
    chk_b("fl_quiet", bus.oValid, 1'b0);

    // reset with two buffered ops
    bus.iExReady = 1'b0;
    offer(32'h00221820, 32'd5, 32'd7, e_add);
    tick();
    offer(32'h00C72822, 32'd10, 32'd3, e_a);
    tick();
    rst = 1'b1;
    flush = 1'b1;
    offer(32'h018D5825, 32'h1, 32'h2, e_c);
    tick();
    chk_b("mrst_valid", bus.oValid, 1'b0);
    chk_b("mrst_ready", bus.oInstReady, 1'b1);
    chk_op("mrst_out", obs_op(), '0);
    rst = 1'b0;
    flush = 1'b0;
    idle();
    bus.iExReady = 1'b1;
    repeat (3) tick();
    chk_b("mrst_quiet", bus.oValid, 1'b0);

    // recovery after reset
    offer(32'h00221820, 32'd5, 32'd7, e_add);
    tick();
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
